// File: rtl/sqrt_pkg.sv
// Shared definitions for the handshaked fixed-point square-root unit:
// FSM state type, iteration-count helper and counter width.
package sqrt_pkg;

   // Controller states: waiting for a radicand, iterating, holding a result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sqrt_state_t;

   // One root bit is produced per iteration, two radicand bits consumed.
   function automatic int sqrt_iter(input int width, input int fbits);
      return (width + fbits) / 2;
   endfunction

   // Counter width for a given iteration count (never narrower than 1 bit).
   function automatic int sqrt_cnt_w(input int iter);
      return (iter > 1) ? $clog2(iter) : 1;
   endfunction

   // Counter width for the default 32-bit Q16.16 configuration.
   localparam int SQRT_CNT_W = $clog2(sqrt_iter(32, 16));

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-recurrence step of the square root: brings the next
// two radicand bits into the partial remainder, trial-subtracts
// (root << 2) | 1, and appends the resulting root bit. Purely combinational.
module sqrt_step #(
   parameter int QW = 24
) (
   input  logic [QW:0]   rem,
   input  logic [QW-1:0] root,
   input  logic [1:0]    bits,
   output logic [QW:0]   rem_new,
   output logic [QW-1:0] root_new
);

   logic [QW+2:0] shifted;
   logic [QW+2:0] trial;
   logic          sign;
   logic [1:0]    diff_unused;
   logic [QW:0]   diff;

   // The remainder never exceeds 2*root, so after a successful subtraction
   // the top two bits of the difference are always zero and can be dropped.
   assign shifted = {rem, bits};
   assign trial   = {1'b0, root, 2'b01};
   assign {sign, diff_unused, diff} = {1'b0, shifted} - {1'b0, trial};

   // Negative trial result restores the shifted remainder and appends a 0.
   assign rem_new  = sign ? shifted[QW:0] : diff;
   assign root_new = {root[QW-2:0], ~sign};

endmodule

// File: rtl/sqrt_hs.sv
// Iterative unsigned fixed-point square root with valid/ready handshakes,
// output backpressure, a pass-through tag and a zero fast path.
// Optional build macro: SQRT_ROUND_EN enables round-to-nearest on the root
// when the captured in_round bit is set.
module sqrt_hs
   import sqrt_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FBITS = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_rad,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_round,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_root,
   output logic [WIDTH-1:0] out_rem,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int ITER  = sqrt_iter(WIDTH, FBITS);
   localparam int XW    = 2 * ITER;
   localparam int RW    = ITER + 1;
   localparam int CNT_W = sqrt_cnt_w(ITER);

   if (FBITS > WIDTH - 2) begin : g_fbits_chk
      $error("sqrt_hs: FBITS must not exceed WIDTH-2");
   end
   if (((WIDTH + FBITS) % 2) != 0) begin : g_parity_chk
      $error("sqrt_hs: WIDTH+FBITS must be even");
   end

   sqrt_state_t      state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [XW-1:0]    x_reg;
   logic [RW-1:0]    rem_reg;
   logic [ITER-1:0]  root_reg;
   logic [WIDTH-1:0] out_root_reg;
   logic [WIDTH-1:0] out_rem_reg;
   logic [TAG_W-1:0] out_tag_reg;
   logic [TAG_W-1:0] tag_reg;

   logic [RW-1:0]    step_rem;
   logic [ITER-1:0]  step_root;
   logic [WIDTH-1:0] root_final;

   sqrt_step #(.QW(ITER)) u_step (
      .rem      (rem_reg),
      .root     (root_reg),
      .bits     (x_reg[XW-1 -: 2]),
      .rem_new  (step_rem),
      .root_new (step_root)
   );

`ifdef SQRT_ROUND_EN
   logic round_reg;

   // Round up when the remainder shows the true root is past q + 1/2.
   always_comb begin
      root_final = WIDTH'(step_root);
      if (round_reg && (step_rem > RW'(step_root))) begin
         root_final = WIDTH'(step_root) + WIDTH'(1);
      end
   end

   // Rounding mode travels with the operand.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         round_reg <= 1'b0;
      end else if (state_reg == IDLE && in_valid) begin
         round_reg <= in_round;
      end
   end
`else
   logic unused_round;
   assign unused_round = in_round;
   assign root_final   = WIDTH'(step_root);
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: accept, iterate ITER times, hold until consumed.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (in_valid) state_next = (in_rad == '0) ? DONE : CALC;
         CALC: if (cnt_reg == '0) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: load operand, run one step per CALC cycle, latch the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         x_reg        <= '0;
         rem_reg      <= '0;
         root_reg     <= '0;
         tag_reg      <= '0;
         out_root_reg <= '0;
         out_rem_reg  <= '0;
         out_tag_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  x_reg    <= XW'(in_rad) << FBITS;
                  rem_reg  <= '0;
                  root_reg <= '0;
                  tag_reg  <= in_tag;
                  cnt_reg  <= CNT_W'(ITER - 1);
                  if (in_rad == '0) begin
                     out_root_reg <= '0;
                     out_rem_reg  <= '0;
                     out_tag_reg  <= in_tag;
                  end
               end
            end
            CALC: begin
               x_reg    <= x_reg << 2;
               rem_reg  <= step_rem;
               root_reg <= step_root;
               cnt_reg  <= cnt_reg - CNT_W'(1);
               if (cnt_reg == '0) begin
                  out_root_reg <= root_final;
                  out_rem_reg  <= WIDTH'(step_rem);
                  out_tag_reg  <= tag_reg;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign out_root  = out_root_reg;
   assign out_rem   = out_rem_reg;
   assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_sqrt_hs.sv
// Self-checking bench for sqrt_hs (WIDTH=32, FBITS=16): directed and random
// radicands against an integer-square-root reference, plus backpressure and
// mid-operation reset. Follows SQRT_ROUND_EN if defined for the build.
module tb_sqrt_hs;

   localparam int WIDTH = 32;
   localparam int FBITS = 16;
   localparam int TAG_W = 4;
   localparam int ITER  = (WIDTH + FBITS) / 2;
`ifdef SQRT_ROUND_EN
   localparam bit ROUND_ON = 1'b1;
`else
   localparam bit ROUND_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_rad;
   logic [TAG_W-1:0] in_tag;
   logic             in_round;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_root;
   logic [WIDTH-1:0] out_rem;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int checks = 0;
   int errors = 0;

   sqrt_hs #(.WIDTH(WIDTH), .FBITS(FBITS), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rad    (in_rad),
      .in_tag    (in_tag),
      .in_round  (in_round),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_root  (out_root),
      .out_rem   (out_rem),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: largest q with q*q <= x, by binary search.
   function automatic longint unsigned isqrt(input longint unsigned x);
      longint unsigned lo, hi, mid;
      lo = 0;
      hi = 64'd1 << ITER;
      while (lo < hi) begin
         mid = (lo + hi + 1) >> 1;
         if (mid * mid <= x) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   task automatic run_op(input logic [WIDTH-1:0] rad, input logic [TAG_W-1:0] tag,
                         input bit rnd, input int stall);
      longint unsigned x, q, r, er;
      int n;
      x  = longint'(rad) << FBITS;
      q  = isqrt(x);
      r  = x - q * q;
      er = (ROUND_ON && rnd && (r > q)) ? q + 1 : q;

      n = 0;
      while (!in_ready && n < 200) begin
         tick;
         n++;
      end
      check("in_ready_idle", 64'(in_ready), 64'd1);

      in_valid = 1'b1;
      in_rad   = rad;
      in_tag   = tag;
      in_round = rnd;
      tick;                       // accepting edge
      in_valid = 1'b0;
      check("busy_after_accept", 64'(busy), 64'd1);
      check("in_ready_after_accept", 64'(in_ready), 64'd0);

      // Count edges to the result; poke inputs that must be ignored meanwhile.
      n = 0;
      while (!out_valid && n < 100) begin
         if (n == 2) begin
            in_valid  = 1'b1;
            in_rad    = $urandom;
            in_tag    = ~tag;
            out_ready = 1'b1;
         end
         if (n == 5) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
         end
         tick;
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("latency", 64'(n), (rad == '0) ? 64'd0 : 64'(ITER));
      check("root", 64'(out_root), er);
      check("rem", 64'(out_rem), r);
      check("tag", 64'(out_tag), 64'(tag));

      for (int s = 0; s < stall; s++) begin
         tick;
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_root", 64'(out_root), er);
         check("stall_rem", 64'(out_rem), r);
         check("stall_tag", 64'(out_tag), 64'(tag));
      end

      out_ready = 1'b1;
      tick;                       // handshake edge
      out_ready = 1'b0;
      check("post_hs_valid", 64'(out_valid), 64'd0);
      check("post_hs_in_ready", 64'(in_ready), 64'd1);
      check("post_hs_busy", 64'(busy), 64'd0);
      $display("op rad=%08h tag=%0d rnd=%0b stall=%0d lat=%0d root=%08h rem=%08h exp_root=%08h exp_rem=%08h",
               rad, tag, rnd, stall, n, out_root, out_rem, er[31:0], r[31:0]);
   endtask

   initial begin
      int seen;
      logic [WIDTH-1:0] rr;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_rad    = '0;
      in_tag    = '0;
      in_round  = 1'b0;
      out_ready = 1'b0;
      tick;
      tick;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_root", 64'(out_root), 64'd0);
      check("rst_rem", 64'(out_rem), 64'd0);
      check("rst_tag", 64'(out_tag), 64'd0);
      rst_n = 1'b1;
      tick;

      // Directed cases.
      run_op(32'h00E89000, 4'd3, 1'b0, 10);
      run_op(32'h00004000, 4'd5, 1'b0, 0);
      run_op(32'h00020000, 4'd1, 1'b0, 2);
      run_op(32'h00020000, 4'd2, 1'b1, 0);
      run_op(32'hFFFFFFFF, 4'd7, 1'b0, 0);
      run_op(32'hFFFFFFFF, 4'd8, 1'b1, 3);
      run_op(32'h00000000, 4'd9, 1'b1, 1);
      run_op(32'h00000001, 4'd10, 1'b1, 0);

      // Random radicands over several magnitudes.
      for (int i = 0; i < 24; i++) begin
         rr = $urandom;
         rr = rr >> $urandom_range(0, 31);
         run_op(rr, 4'($urandom), 1'($urandom), $urandom_range(0, 3));
      end

      // Reset in the middle of CALC abandons the operation.
      in_valid = 1'b1;
      in_rad   = 32'h12345678;
      in_tag   = 4'd6;
      in_round = 1'b0;
      tick;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick;
      rst_n = 1'b0;
      tick;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_root", 64'(out_root), 64'd0);
      check("midrst_rem", 64'(out_rem), 64'd0);
      check("midrst_tag", 64'(out_tag), 64'd0);
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (out_valid) seen++;
      end
      check("no_stale_result", 64'(seen), 64'd0);
      $display("op reset mid-CALC stale_valid_cycles=%0d", seen);

      run_op(32'h00090000, 4'd4, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
